aes_key_expander: RTL and testbench

//  Iterative AES-128 key schedule: expands cipher key into round keys 0..10, one per clock.

---
 rtl/aes_pkg.sv | 33 +++
 rtl/aes_sbox.sv | 30 +++
 rtl/aes_key_expander.sv | 152 +++++++++++++++
 tb/tb_aes_key_expander.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state encoding and round-constant lookup, used by the
// key schedule, the round orchestrator and the cipher datapath.
package aes_pkg;

  localparam int AES_WORD = 32;
  localparam int AES_NK   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } aes_state_e;

  // Round constant for rounds 1..10; any other index yields zero.
  function automatic logic [7:0] aes_rcon(input logic [3:0] rnd);
    logic [7:0] r;
    case (rnd)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box (byte substitution), shared by the key schedule and the
// SubBytes stage.
module aes_sbox (
  input  logic [7:0] data,
  output logic [7:0] result
);

  // Row r holds S[16r .. 16r+15]; entry 0 sits at the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign result = SBOX[data];

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule producing round keys 0..10, one per clock.
// Optional AES_KEY_EXP_CACHE_EN: a repeated start with the already-expanded key skips expansion.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int WIDTH  = 128,
  parameter int ROUNDS = 10
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] key_i,
  output logic [WIDTH-1:0] key_0_o,
  output logic [WIDTH-1:0] key_1_o,
  output logic [WIDTH-1:0] key_2_o,
  output logic [WIDTH-1:0] key_3_o,
  output logic [WIDTH-1:0] key_4_o,
  output logic [WIDTH-1:0] key_5_o,
  output logic [WIDTH-1:0] key_6_o,
  output logic [WIDTH-1:0] key_7_o,
  output logic [WIDTH-1:0] key_8_o,
  output logic [WIDTH-1:0] key_9_o,
  output logic [WIDTH-1:0] key_10_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             keys_valid_o,
  output aes_state_e       state_o
);

  if (WIDTH != 128) begin : g_bad_width
    $error("aes_key_expander: WIDTH must be 128");
  end
  if (ROUNDS != 10) begin : g_bad_rounds
    $error("aes_key_expander: ROUNDS must be 10");
  end

  // Handshake: start_i is a level request sampled on each rising edge; it is accepted
  // only in IDLE or DONE, ignored during EXPAND, and key_i is captured on the accept edge.
  // done_o pulses for one cycle at completion; keys_valid_o stays high until the next accept.

  aes_state_e       state;
  logic [3:0]       rnd;
  logic [WIDTH-1:0] bank [0:ROUNDS];
  logic [WIDTH-1:0] prev_key;
  logic [WIDTH-1:0] next_key;
  logic [AES_WORD-1:0] w0, w1, w2, w3, rot_w, sub_w, t_w;
  logic [AES_WORD-1:0] n0, n1, n2, n3;
  logic             cache_hit;

  assign state_o = state;

  // One shared round datapath: select the previous round key by the round counter.
  always_comb begin
    prev_key = '0;
    for (int i = 0; i < ROUNDS; i++) begin
      if (rnd == 4'(i + 1)) prev_key = bank[i];
    end
  end

  assign w0    = prev_key[127:96];
  assign w1    = prev_key[95:64];
  assign w2    = prev_key[63:32];
  assign w3    = prev_key[31:0];
  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar b = 0; b < AES_NK; b++) begin : g_sub
    aes_sbox u_sbox (
      .data   (rot_w[8*b +: 8]),
      .result (sub_w[8*b +: 8])
    );
  end

  assign t_w      = sub_w ^ {aes_rcon(rnd), 24'h0};
  assign n0       = w0 ^ t_w;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

`ifdef AES_KEY_EXP_CACHE_EN
  assign cache_hit = (state == ST_IDLE) && keys_valid_o && (key_i == bank[0]);
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state        <= ST_IDLE;
      rnd          <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      keys_valid_o <= 1'b0;
      for (int i = 0; i <= ROUNDS; i++) bank[i] <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_i && cache_hit) begin
            state  <= ST_DONE;
            done_o <= 1'b1;
          end else if (start_i) begin
            bank[0]      <= key_i;
            rnd          <= 4'd1;
            keys_valid_o <= 1'b0;
            busy_o       <= 1'b1;
            state        <= ST_EXPAND;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_EXPAND: begin
          if (rnd == 4'd0 || rnd > 4'(ROUNDS)) begin
            state  <= ST_IDLE;
            rnd    <= '0;
            busy_o <= 1'b0;
          end else begin
            for (int k = 1; k <= ROUNDS; k++) begin
              if (rnd == 4'(k)) bank[k] <= next_key;
            end
            if (rnd == 4'(ROUNDS)) begin
              state        <= ST_DONE;
              rnd          <= '0;
              busy_o       <= 1'b0;
              done_o       <= 1'b1;
              keys_valid_o <= 1'b1;
            end else begin
              rnd <= rnd + 4'd1;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          rnd    <= '0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  assign key_0_o  = bank[0];
  assign key_1_o  = bank[1];
  assign key_2_o  = bank[2];
  assign key_3_o  = bank[3];
  assign key_4_o  = bank[4];
  assign key_5_o  = bank[5];
  assign key_6_o  = bank[6];
  assign key_7_o  = bank[7];
  assign key_8_o  = bank[8];
  assign key_9_o  = bank[9];
  assign key_10_o = bank[10];

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander: word-level FIPS-197 schedule model with a
// GF(2^8)-derived S-box, per-cycle compare process and directed scenarios.
module tb_aes_key_expander;
  import aes_pkg::*;

  localparam logic [127:0] KEY_A1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_K1     = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_K10    = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_K1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_K10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] dut_keys [0:10];
  logic         busy, done, keys_valid;
  aes_state_e   dut_state;

  always #5 clk = ~clk;

  aes_key_expander dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .start_i      (start),
    .key_i        (key_in),
    .key_0_o      (dut_keys[0]),
    .key_1_o      (dut_keys[1]),
    .key_2_o      (dut_keys[2]),
    .key_3_o      (dut_keys[3]),
    .key_4_o      (dut_keys[4]),
    .key_5_o      (dut_keys[5]),
    .key_6_o      (dut_keys[6]),
    .key_7_o      (dut_keys[7]),
    .key_8_o      (dut_keys[8]),
    .key_9_o      (dut_keys[9]),
    .key_10_o     (dut_keys[10]),
    .busy_o       (busy),
    .done_o       (done),
    .keys_valid_o (keys_valid),
    .state_o      (dut_state)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  bit check_en     = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   sbox_t [0:255];
  logic [7:0]   rcon_t [1:10];
  logic [127:0] sched_q [0:10];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] inv, r;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gf_mul(8'(v), 8'(x)) == 8'h01) inv = 8'(x);
      sbox_t[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    r = 8'h01;
    for (int i = 1; i <= 10; i++) begin
      rcon_t[i] = r;
      r = gf_mul(r, 8'h02);
    end
  endtask

  // Word-by-word expansion w[0..43] as in FIPS-197, regrouped into 11 round keys.
  function automatic void key_schedule(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rcon_t[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k <= 10; k++) sched_q[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endfunction

  // Cycle model of the visible outputs, advanced on each rising edge.
  int           cnt = 0;
  bit           exp_done = 1'b0, exp_kv = 1'b0, exp_busy = 1'b0, nd, hit;
  logic [127:0] exp_keys [0:10];
  logic [127:0] pend [0:10];
  logic [127:0] exp_q [$];

  initial for (int i = 0; i <= 10; i++) exp_keys[i] = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      cnt = 0; exp_done = 1'b0; exp_kv = 1'b0; exp_busy = 1'b0;
      for (int i = 0; i <= 10; i++) exp_keys[i] = '0;
      exp_q.delete();
    end else begin
      nd = 1'b0;
      if (cnt != 0) begin
        exp_keys[cnt] = pend[cnt];
        if (cnt == 10) begin cnt = 0; nd = 1'b1; exp_kv = 1'b1; end
        else cnt++;
      end else if (start) begin
        hit = 1'b0;
`ifdef AES_KEY_EXP_CACHE_EN
        hit = !exp_done && exp_kv && (key_in == exp_keys[0]);
`endif
        if (hit) nd = 1'b1;
        else begin
          key_schedule(key_in);
          for (int i = 0; i <= 10; i++) pend[i] = sched_q[i];
          exp_keys[0] = key_in;
          cnt = 1;
          exp_kv = 1'b0;
        end
      end
      if (nd) exp_q.push_back(exp_keys[10]);
      exp_done = nd;
      exp_busy = (cnt != 0);
    end
  end

  // ---------------- compare process ----------------
  int done_pulses = 0;
  logic [127:0] q_head;

  always @(negedge clk) begin
    if (check_en) begin
      check("busy", 128'(busy), 128'(exp_busy));
      check("done", 128'(done), 128'(exp_done));
      check("keys_valid", 128'(keys_valid), 128'(exp_kv));
      for (int i = 0; i <= 10; i++) check($sformatf("key_%0d", i), dut_keys[i], exp_keys[i]);
      if (done === 1'b1) begin
        done_pulses++;
        if (exp_q.size() == 0) check("done_unexpected", 128'(done), 128'(0));
        else begin
          q_head = exp_q.pop_front();
          check("done_key10", dut_keys[10], q_head);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [127:0] k);
    @(negedge clk);
    start = 1'b1;
    key_in = k;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges from the accept edge (inclusive) to the edge that raised done_o.
  task automatic wait_done(output int edges, output bit busy_seen);
    edges = 1;
    busy_seen = (busy === 1'b1);
    while (done !== 1'b1 && edges < 40) begin
      @(negedge clk);
      edges++;
      if (busy === 1'b1) busy_seen = 1'b1;
    end
    if (done !== 1'b1) check("done_timeout", 128'(done), 128'(1));
  endtask

  // ---------------- directed scenarios ----------------
  int edges, pulses_before;
  bit busy_seen;

  initial begin
    rst_n = 1'b0; start = 1'b0; key_in = '0;
    build_tables();

    // Pin the model against published values.
    check("model_sbox_00", 128'(sbox_t[8'h00]), 128'h63);
    check("model_sbox_53", 128'(sbox_t[8'h53]), 128'hed);
    check("model_rcon_9", 128'(rcon_t[9]), 128'h1b);
    check("model_rcon_10", 128'(rcon_t[10]), 128'h36);
    key_schedule(KEY_A1);
    check("model_a1_k1", sched_q[1], A1_K1);
    check("model_a1_k10", sched_q[10], A1_K10);
    key_schedule('0);
    check("model_zero_k1", sched_q[1], ZERO_K1);
    check("model_zero_k10", sched_q[10], ZERO_K10);

    // Reset state
    @(posedge clk);
    #1 check_en = 1'b1;
    @(negedge clk);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_valid", 128'(keys_valid), 128'(0));
    check("rst_key0", dut_keys[0], '0);
    check("rst_state", 128'(dut_state), 128'(ST_IDLE));
    rst_n = 1'b1;

    // 1: FIPS-197 A.1 key
    do_start(KEY_A1);
    wait_done(edges, busy_seen);
    check("s1_latency", 128'(edges), 128'(11));
    check("s1_key1", dut_keys[1], A1_K1);
    check("s1_key10", dut_keys[10], A1_K10);
    check("s1_valid", 128'(keys_valid), 128'(1));

    // 2: all-zero key
    do_start('0);
    wait_done(edges, busy_seen);
    check("s2_key1", dut_keys[1], ZERO_K1);
    check("s2_key10", dut_keys[10], ZERO_K10);
    @(negedge clk);
    check("s2_valid_after", 128'(keys_valid), 128'(1));

    // 3: start during EXPAND is ignored
    pulses_before = done_pulses;
    do_start(KEY_A1);
    repeat (3) @(negedge clk);
    start = 1'b1; key_in = '0;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("s3_key10", dut_keys[10], A1_K10);
    check("s3_pulses", 128'(done_pulses - pulses_before), 128'(1));

    // 4: reset mid-expansion
    do_start('0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("s4_busy", 128'(busy), 128'(0));
    check("s4_key0", dut_keys[0], '0);
    check("s4_key1", dut_keys[1], '0);
    check("s4_valid", 128'(keys_valid), 128'(0));
    do_start(KEY_A1);
    wait_done(edges, busy_seen);
    check("s4_key10", dut_keys[10], A1_K10);

    // 5: start held through DONE (back-to-back)
    start = 1'b1; key_in = '0;
    @(negedge clk);
    start = 1'b0;
    check("s5_valid_drop", 128'(keys_valid), 128'(0));
    check("s5_busy", 128'(busy), 128'(1));
    wait_done(edges, busy_seen);
    check("s5_latency", 128'(edges), 128'(11));
    check("s5_key10", dut_keys[10], ZERO_K10);

    // 6: repeat of the already-expanded key
    @(negedge clk);
    do_start('0);
    wait_done(edges, busy_seen);
`ifdef AES_KEY_EXP_CACHE_EN
    check("s6_latency", 128'(edges), 128'(1));
    check("s6_busy_seen", 128'(busy_seen), 128'(0));
    check("s6_valid", 128'(keys_valid), 128'(1));
`else
    check("s6_latency", 128'(edges), 128'(11));
    check("s6_busy_seen", 128'(busy_seen), 128'(1));
`endif
    check("s6_key10", dut_keys[10], ZERO_K10);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
